z80fi_trace_packer: RTL and testbench

// Producer side of the z80fi formal interface. Watches the core's fetch/retire

---
 rtl/z80fi_trace_packer_pkg.sv | 26 ++
 rtl/z80fi_trace_packer_reg_snapshot.sv | 20 ++
 rtl/z80fi_trace_packer.sv | 153 +++++++++++++++
 tb/tb_z80fi_trace_packer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/z80fi_trace_packer_pkg.sv
// Shared types and defaults for the z80fi trace packer.
//   regs_t  : architectural register bundle, field order a,f,bc,de,hl,sp,ip
//   state_t : packer FSM encoding
package z80fi_trace_packer_pkg;

    localparam int MAX_LEN_DEF = 4;   // opcode bytes per instruction
    localparam int LEN_W_DEF   = 3;   // width of the length field
    localparam int REGS_W      = 2 * 8 + 5 * 16;

    typedef struct packed {
        logic [7:0]  a;
        logic [7:0]  f;
        logic [15:0] bc;
        logic [15:0] de;
        logic [15:0] hl;
        logic [15:0] sp;
        logic [15:0] ip;
    } regs_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_EMIT    = 2'd2
    } state_t;

endpackage

// File: rtl/z80fi_trace_packer_reg_snapshot.sv
// Load-enable register bank holding one snapshot of the seven core registers.
//   clk, reset_n : clock, async active-low reset (bank clears to 0)
//   load         : capture d this cycle
//   d / q        : packed regs_t bundle in / held copy out
module z80fi_trace_packer_reg_snapshot
    import z80fi_trace_packer_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [REGS_W-1:0] d,
    output logic [REGS_W-1:0] q
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  q <= '0;
        else if (load) q <= d;
    end

endmodule

// File: rtl/z80fi_trace_packer.sv
// z80fi retirement packet producer. Tracks insn_start / fetch_valid /
// insn_done from the core and emits one packet per retired instruction.
//   clk, reset_n           : clock, async active-low reset
//   insn_start             : M1 of a new instruction (opens a packet)
//   fetch_valid/fetch_byte : instruction byte stream
//   insn_done              : retirement (closes the packet)
//   core_*                 : live architectural registers
//   z80fi_valid            : one-cycle packet strobe, the cycle after insn_done
//   z80fi_insn/_len        : opcode bytes (first in [7:0]) and byte count
//   z80fi_reg_*_in/_out    : register snapshots at start / retirement
//   z80fi_overflow         : sticky, an instruction had more than MAX_LEN bytes
module z80fi_trace_packer
    import z80fi_trace_packer_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int LEN_W   = LEN_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 insn_start,
    input  logic                 fetch_valid,
    input  logic [7:0]           fetch_byte,
    input  logic                 insn_done,
    input  logic [7:0]           core_a,
    input  logic [7:0]           core_f,
    input  logic [15:0]          core_bc,
    input  logic [15:0]          core_de,
    input  logic [15:0]          core_hl,
    input  logic [15:0]          core_sp,
    input  logic [15:0]          core_ip,
    output logic                 z80fi_valid,
    output logic [8*MAX_LEN-1:0] z80fi_insn,
    output logic [LEN_W-1:0]     z80fi_insn_len,
    output logic [7:0]           z80fi_reg_a_in,
    output logic [7:0]           z80fi_reg_f_in,
    output logic [15:0]          z80fi_reg_bc_in,
    output logic [15:0]          z80fi_reg_de_in,
    output logic [15:0]          z80fi_reg_hl_in,
    output logic [15:0]          z80fi_reg_sp_in,
    output logic [15:0]          z80fi_reg_ip_in,
    output logic [7:0]           z80fi_reg_a_out,
    output logic [7:0]           z80fi_reg_f_out,
    output logic [15:0]          z80fi_reg_bc_out,
    output logic [15:0]          z80fi_reg_de_out,
    output logic [15:0]          z80fi_reg_hl_out,
    output logic [15:0]          z80fi_reg_sp_out,
    output logic [15:0]          z80fi_reg_ip_out,
    output logic                 z80fi_overflow
);

    state_t               state_q, state_d;
    logic [8*MAX_LEN-1:0] buf_q, buf_d, cur_buf, pkt_insn_q;
    logic [LEN_W-1:0]     cnt_q, cnt_d, cur_cnt, pkt_len_q;
    logic                 ovf_q, ovf_d, done_cap, valid_q;
    regs_t                core_regs, work_in, pkt_in, pkt_out;

    assign core_regs = {core_a, core_f, core_bc, core_de, core_hl, core_sp, core_ip};

    // cur_* is the open instruction including this cycle's byte; it is what
    // retires on insn_done. A byte arriving with insn_start belongs to the
    // new instruction, never the one being retired.
    always_comb begin
        state_d  = state_q;
        cur_buf  = buf_q;
        cur_cnt  = cnt_q;
        ovf_d    = ovf_q;
        done_cap = (state_q == ST_CAPTURE) && insn_done;

        if (state_q == ST_CAPTURE && fetch_valid && !insn_start) begin
            if (cnt_q == LEN_W'(MAX_LEN)) begin
                ovf_d = 1'b1;
            end else begin
                for (int i = 0; i < MAX_LEN; i++)
                    if (cnt_q == LEN_W'(i)) cur_buf[8*i +: 8] = fetch_byte;
                cur_cnt = cnt_q + 1'b1;
            end
        end

        buf_d = cur_buf;
        cnt_d = cur_cnt;
        if (insn_start) begin
            buf_d = '0;
            cnt_d = '0;
            if (fetch_valid) begin
                buf_d[7:0] = fetch_byte;
                cnt_d      = LEN_W'(1);
            end
        end

        // done+start skips EMIT: the strobe comes from valid_q, and the new
        // instruction must keep capturing bytes during the strobe cycle.
        case (state_q)
            ST_IDLE:    if (insn_start) state_d = ST_CAPTURE;
            ST_CAPTURE: if (insn_done && !insn_start) state_d = ST_EMIT;
            ST_EMIT:    state_d = insn_start ? ST_CAPTURE : ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            buf_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            valid_q    <= 1'b0;
            pkt_insn_q <= '0;
            pkt_len_q  <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            valid_q <= done_cap;
            if (done_cap) begin
                pkt_insn_q <= cur_buf;
                pkt_len_q  <= cur_cnt;
            end
        end
    end

    // Working start-of-insn snapshot; copied into the packet on retirement so
    // a same-cycle insn_start can overwrite it without corrupting the packet.
    z80fi_trace_packer_reg_snapshot u_in (
        .clk(clk), .reset_n(reset_n), .load(insn_start), .d(core_regs), .q(work_in)
    );
    z80fi_trace_packer_reg_snapshot u_pkt_in (
        .clk(clk), .reset_n(reset_n), .load(done_cap), .d(work_in), .q(pkt_in)
    );
    z80fi_trace_packer_reg_snapshot u_out (
        .clk(clk), .reset_n(reset_n), .load(done_cap), .d(core_regs), .q(pkt_out)
    );

    assign z80fi_valid      = valid_q;
    assign z80fi_insn       = pkt_insn_q;
    assign z80fi_insn_len   = pkt_len_q;
    assign z80fi_overflow   = ovf_q;
    assign z80fi_reg_a_in   = pkt_in.a;
    assign z80fi_reg_f_in   = pkt_in.f;
    assign z80fi_reg_bc_in  = pkt_in.bc;
    assign z80fi_reg_de_in  = pkt_in.de;
    assign z80fi_reg_hl_in  = pkt_in.hl;
    assign z80fi_reg_sp_in  = pkt_in.sp;
    assign z80fi_reg_ip_in  = pkt_in.ip;
    assign z80fi_reg_a_out  = pkt_out.a;
    assign z80fi_reg_f_out  = pkt_out.f;
    assign z80fi_reg_bc_out = pkt_out.bc;
    assign z80fi_reg_de_out = pkt_out.de;
    assign z80fi_reg_hl_out = pkt_out.hl;
    assign z80fi_reg_sp_out = pkt_out.sp;
    assign z80fi_reg_ip_out = pkt_out.ip;

endmodule

// File: tb/tb_z80fi_trace_packer.sv
// Random + directed bench for z80fi_trace_packer against a queue-based
// packet model (open flag, byte queue, last emitted packet).
module tb_z80fi_trace_packer;

    localparam int MAX_LEN = 4;
    localparam int LEN_W   = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic        insn_start, fetch_valid, insn_done;
    logic [7:0]  fetch_byte, core_a, core_f;
    logic [15:0] core_bc, core_de, core_hl, core_sp, core_ip;
    logic                 z80fi_valid, z80fi_overflow;
    logic [8*MAX_LEN-1:0] z80fi_insn;
    logic [LEN_W-1:0]     z80fi_insn_len;
    logic [7:0]  z80fi_reg_a_in, z80fi_reg_f_in, z80fi_reg_a_out, z80fi_reg_f_out;
    logic [15:0] z80fi_reg_bc_in, z80fi_reg_de_in, z80fi_reg_hl_in, z80fi_reg_sp_in, z80fi_reg_ip_in;
    logic [15:0] z80fi_reg_bc_out, z80fi_reg_de_out, z80fi_reg_hl_out, z80fi_reg_sp_out, z80fi_reg_ip_out;

    z80fi_trace_packer #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .insn_start(insn_start), .fetch_valid(fetch_valid), .fetch_byte(fetch_byte),
        .insn_done(insn_done),
        .core_a(core_a), .core_f(core_f), .core_bc(core_bc), .core_de(core_de),
        .core_hl(core_hl), .core_sp(core_sp), .core_ip(core_ip),
        .z80fi_valid(z80fi_valid), .z80fi_insn(z80fi_insn), .z80fi_insn_len(z80fi_insn_len),
        .z80fi_reg_a_in(z80fi_reg_a_in), .z80fi_reg_f_in(z80fi_reg_f_in),
        .z80fi_reg_bc_in(z80fi_reg_bc_in), .z80fi_reg_de_in(z80fi_reg_de_in),
        .z80fi_reg_hl_in(z80fi_reg_hl_in), .z80fi_reg_sp_in(z80fi_reg_sp_in),
        .z80fi_reg_ip_in(z80fi_reg_ip_in),
        .z80fi_reg_a_out(z80fi_reg_a_out), .z80fi_reg_f_out(z80fi_reg_f_out),
        .z80fi_reg_bc_out(z80fi_reg_bc_out), .z80fi_reg_de_out(z80fi_reg_de_out),
        .z80fi_reg_hl_out(z80fi_reg_hl_out), .z80fi_reg_sp_out(z80fi_reg_sp_out),
        .z80fi_reg_ip_out(z80fi_reg_ip_out),
        .z80fi_overflow(z80fi_overflow)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    // ---- reference model ----
    bit                   m_open, m_ovf, m_valid;
    byte unsigned         m_bytes[$];
    logic [47:0]          m_in_lo, m_in_hi;
    logic [8*MAX_LEN-1:0] p_insn;
    logic [LEN_W-1:0]     p_len;
    logic [47:0]          p_in_lo, p_in_hi, p_out_lo, p_out_hi;

    function automatic logic [47:0] core_lo();
        return {core_a, core_f, core_bc, core_de};
    endfunction
    function automatic logic [47:0] core_hi();
        return {core_hl, core_sp, core_ip};
    endfunction

    task automatic model_reset();
        m_open = 0; m_ovf = 0; m_valid = 0; m_bytes.delete();
        m_in_lo = '0; m_in_hi = '0;
        p_insn = '0; p_len = '0;
        p_in_lo = '0; p_in_hi = '0; p_out_lo = '0; p_out_hi = '0;
    endtask

    // Applies one clock edge's worth of inputs to the model.
    task automatic model_update();
        m_valid = 0;
        if (m_open && fetch_valid && !insn_start) begin
            if (m_bytes.size() == MAX_LEN) m_ovf = 1;
            else m_bytes.push_back(fetch_byte);
        end
        if (m_open && insn_done) begin
            m_valid = 1;
            p_insn  = '0;
            foreach (m_bytes[i]) p_insn[8*i +: 8] = m_bytes[i];
            p_len    = LEN_W'(m_bytes.size());
            p_in_lo  = m_in_lo;
            p_in_hi  = m_in_hi;
            p_out_lo = core_lo();
            p_out_hi = core_hi();
        end
        if (insn_start) begin
            m_open = 1;
            m_bytes.delete();
            if (fetch_valid) m_bytes.push_back(fetch_byte);
            m_in_lo = core_lo();
            m_in_hi = core_hi();
        end else if (insn_done) begin
            m_open = 0;
        end
    endtask

    task automatic check_all();
        chk("valid",  z80fi_valid, m_valid);
        chk("ovf",    z80fi_overflow, m_ovf);
        chk("insn",   z80fi_insn, p_insn);
        chk("len",    z80fi_insn_len, p_len);
        chk("in_lo",  {z80fi_reg_a_in, z80fi_reg_f_in, z80fi_reg_bc_in, z80fi_reg_de_in}, p_in_lo);
        chk("in_hi",  {z80fi_reg_hl_in, z80fi_reg_sp_in, z80fi_reg_ip_in}, p_in_hi);
        chk("out_lo", {z80fi_reg_a_out, z80fi_reg_f_out, z80fi_reg_bc_out, z80fi_reg_de_out}, p_out_lo);
        chk("out_hi", {z80fi_reg_hl_out, z80fi_reg_sp_out, z80fi_reg_ip_out}, p_out_hi);
    endtask

    task automatic rand_core();
        core_a  = 8'($urandom);  core_f  = 8'($urandom);
        core_bc = 16'($urandom); core_de = 16'($urandom);
        core_hl = 16'($urandom); core_sp = 16'($urandom);
        core_ip = 16'($urandom);
    endtask

    // Drive one cycle of control inputs, clock it, check #1 after the edge.
    task automatic step(input bit s, input bit f, input logic [7:0] b, input bit d);
        insn_start = s; fetch_valid = f; fetch_byte = b; insn_done = d;
        @(posedge clk);
        model_update();
        #1;
        check_all();
    endtask

    initial begin
        insn_start = 0; fetch_valid = 0; fetch_byte = 0; insn_done = 0;
        rand_core();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();                       // reset state
        reset_n = 1'b1;

        // RLCA
        core_a = 8'h81; core_f = 8'h00; core_ip = 16'h0100;
        step(1, 1, 8'h07, 0);
        core_a = 8'h03; core_f = 8'h01; core_ip = 16'h0101;
        step(0, 0, 8'h00, 1);
        chk("rlca_valid", z80fi_valid, 1);
        chk("rlca_insn", z80fi_insn, 32'h0000_0007);
        chk("rlca_len", z80fi_insn_len, 1);
        chk("rlca_a_in", z80fi_reg_a_in, 8'h81);
        chk("rlca_ip_in", z80fi_reg_ip_in, 16'h0100);
        chk("rlca_a_out", z80fi_reg_a_out, 8'h03);
        chk("rlca_ip_out", z80fi_reg_ip_out, 16'h0101);
        step(0, 0, 8'h00, 0);
        chk("rlca_hold", z80fi_insn, 32'h0000_0007);

        // LD BC,0x1234
        rand_core();
        step(1, 1, 8'h01, 0);
        step(0, 1, 8'h34, 0);
        step(0, 1, 8'h12, 0);
        core_bc = 16'h1234;
        step(0, 0, 8'h00, 1);
        chk("ldbc_insn", z80fi_insn, 32'h0012_3401);
        chk("ldbc_len", z80fi_insn_len, 3);
        chk("ldbc_bc_out", z80fi_reg_bc_out, 16'h1234);
        step(0, 0, 8'h00, 0);

        // RRA then RLA back to back
        rand_core();
        step(1, 1, 8'h1F, 0);
        core_a = 8'h5A; core_ip = 16'h0200;
        step(1, 1, 8'h17, 1);
        chk("b2b_p1_insn", z80fi_insn, 32'h0000_001F);
        chk("b2b_p1_a_out", z80fi_reg_a_out, 8'h5A);
        rand_core();
        step(0, 0, 8'h00, 1);
        chk("b2b_p2_insn", z80fi_insn, 32'h0000_0017);
        chk("b2b_p2_a_in", z80fi_reg_a_in, 8'h5A);
        chk("b2b_p2_ip_in", z80fi_reg_ip_in, 16'h0200);

        // stray done / fetch while idle
        step(0, 0, 8'h00, 1);
        step(0, 1, 8'h99, 0);
        step(0, 0, 8'h00, 1);
        chk("idle_valid", z80fi_valid, 0);

        // overflow: five bytes
        step(1, 1, 8'h11, 0);
        step(0, 1, 8'h22, 0);
        step(0, 1, 8'h33, 0);
        step(0, 1, 8'h44, 0);
        chk("ovf_before", z80fi_overflow, 0);
        step(0, 1, 8'h55, 0);
        chk("ovf_set", z80fi_overflow, 1);
        step(0, 0, 8'h00, 1);
        chk("ovf_insn", z80fi_insn, 32'h4433_2211);
        chk("ovf_len", z80fi_insn_len, 4);
        step(1, 1, 8'h00, 0);
        step(0, 0, 8'h00, 1);
        chk("ovf_sticky", z80fi_overflow, 1);

        // reset mid-capture
        step(1, 1, 8'hAA, 0);
        step(0, 1, 8'hBB, 0);
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("rst_ovf", z80fi_overflow, 0);
        insn_done = 1;
        @(posedge clk);
        #1;
        check_all();
        reset_n = 1'b1;
        step(0, 0, 8'h00, 1);              // nothing open: no packet
        chk("rst_novalid", z80fi_valid, 0);
        step(1, 1, 8'h00, 0);
        step(0, 0, 8'h00, 1);
        chk("rst_next_len", z80fi_insn_len, 1);
        chk("rst_next_insn", z80fi_insn, 32'h0);

        // randomized traffic; overflow stays sticky once hit
        for (int n = 0; n < 2000; n++) begin
            bit s, d, f;
            rand_core();
            s = ($urandom_range(0, 3) == 0);
            d = ($urandom_range(0, 3) == 0);
            f = ($urandom_range(0, 1) == 0) && (s || !d);
            step(s, f, 8'($urandom), d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
